// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed N-digit 7-segment display driver with an internal refresh
//   prescaler. New values are held in a pending register. They reach the shadow
//   display register only at a frame boundary, so one scan never mixes digits
//   from two different values.
//
// Parameters
//   NUM_DIGITS   digits scanned (2..8)
//   REFRESH_DIV  clk cycles per digit slot (>=1)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   bcd_in      packed nibbles, [4N-1:4N-4] = leftmost digit
//   dp_in       decimal points, bit N-1 = leftmost, 1 = lit
//   load        1-cycle strobe capturing bcd_in/dp_in
//   digits      anodes, active-low, bit N-1 = leftmost
//   segments    {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_done  1-cycle pulse after the scan index wraps to 0
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked.
//   The rightmost digit is never blanked.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   digits,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 5 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] pre_cnt;
  logic [IW-1:0] idx;
  // Display and pending words are packed as {bcd nibbles, dp bits}.
  logic [DW-1:0] disp_reg;
  logic [DW-1:0] pend_reg;
  logic          pend_vld;
  logic          tick;
  logic          wrap;

  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [IW-1:0]           pos_p0;
  logic [3:0]              nib_p0;
  logic                    dp_p0;
  logic                    blank_p0;
  logic [NUM_DIGITS-1:0]   anode_p0;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick     = (pre_cnt == PRE_LAST);
  assign wrap     = tick && (idx == IDX_LAST);
  assign disp_bcd = disp_reg[DW-1:NUM_DIGITS];
  assign disp_dp  = disp_reg[NUM_DIGITS-1:0];

  // Stage p0: select the current digit from the display register
  always_comb begin
    pos_p0   = IDX_LAST - idx;
    nib_p0   = disp_bcd[{pos_p0, 2'b00} +: 4];
    dp_p0    = disp_dp[pos_p0];
    anode_p0 = ~(NUM_DIGITS'(1) << pos_p0);
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when every nibble from the leftmost up to this one is zero.
    blank_p0 = (idx != IDX_LAST);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i <= int'(idx) && disp_bcd[4*(NUM_DIGITS-1-i) +: 4] != 4'h0)
        blank_p0 = 1'b0;
    end
`else
    blank_p0 = 1'b0;
`endif
  end

  // Stage p1: scan control, value update and registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt    <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      pend_vld   <= 1'b0;
      digits     <= '1;
      segments   <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // A load landing on the wrap cycle goes straight to the display.
      if (wrap) begin
        if (load)
          disp_reg <= {bcd_in, dp_in};
        else if (pend_vld)
          disp_reg <= pend_reg;
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_vld <= 1'b1;
      end

      frame_done <= wrap;
      digits     <= anode_p0;
      segments   <= blank_p0 ? 7'h7F : seg_decode(nib_p0);
      dp         <= ~dp_p0;
    end
  end

  // Pending data is qualified by pend_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load && !wrap)
      pend_reg <= {bcd_in, dp_in};
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  digits;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_done;

  int n_vec;
  int n_bad;

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .digits(digits), .segments(segments), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    logic [27:0] segs;  // digit 0 (leftmost) in [27:21]
  } vec_t;

  vec_t vecs[6];
  logic [3:0]  anode_tbl[4];
  logic [27:0] zero_segs;
  logic [27:0] segs_1234;
  logic [27:0] segs_5678;
  logic [27:0] segs_2222;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step once and check the pins for cycle k (1..16) of a frame.
  task automatic check_step(input int k, input logic [27:0] segs, input logic [3:0] dpv);
    int d;
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
    step();
    d     = (k - 1) / 4;
    e_dig = anode_tbl[d];
    e_seg = segs[27-7*d -: 7];
    e_dp  = ~dpv[3-d];
    e_fd  = (k == 16);
    n_vec++;
    if (digits !== e_dig || segments !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      n_bad++;
      $display("FAIL scan k=%0d: got dig=%b seg=%b dp=%b fd=%b, want dig=%b seg=%b dp=%b fd=%b",
               k, digits, segments, dp, frame_done, e_dig, e_seg, e_dp, e_fd);
    end
  endtask

  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dpv);
    for (int k = 1; k <= 16; k++) check_step(k, segs, dpv);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (frame_done !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, want 1", frame_done, n);
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] p);
    bcd_in = b;
    dp_in  = p;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic check_blank(input string name);
    n_vec++;
    if (digits !== 4'b1111 || segments !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got dig=%b seg=%h dp=%b fd=%b, want dig=1111 seg=7f dp=1 fd=0",
               name, digits, segments, dp, frame_done);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    anode_tbl[0] = 4'b0111;
    anode_tbl[1] = 4'b1011;
    anode_tbl[2] = 4'b1101;
    anode_tbl[3] = 4'b1110;
    segs_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    segs_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
    segs_2222 = {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100};
`ifdef LEADING_ZERO_BLANK_EN
    zero_segs = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
`else
    zero_segs = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
    vecs[0] = '{16'h1234, 4'b0100, segs_1234};
    vecs[1] = '{16'h5678, 4'b0001, segs_5678};
    vecs[2] = '{16'h9CDE, 4'b1111, {7'b0010000, 7'b1000110, 7'b0100001, 7'b0000110}};
    vecs[3] = '{16'hAF0B, 4'b0000, {7'b0001000, 7'b0001110, 7'b1000000, 7'b0000011}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[4] = '{16'h0070, 4'b1000, {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}};
    vecs[5] = '{16'h0005, 4'b0010, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}};
`else
    vecs[4] = '{16'h0070, 4'b1000, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}};
    vecs[5] = '{16'h0005, 4'b0010, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}};
`endif

    // Reset with a coincident load that must be ignored
    reset  = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h8888;
    dp_in  = 4'b1111;
    step();
    check_blank("reset_state");
    step();
    reset = 1'b0;
    load  = 1'b0;
    check_frame(zero_segs, 4'b0000);
    check_frame(zero_segs, 4'b0000);

    // Table-driven vectors
    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].bcd, vecs[v].dpv);
      wait_frame();
      check_frame(vecs[v].segs, vecs[v].dpv);
    end

    // Load during index 1 does not disturb the frame in progress
    do_load(16'h1234, 4'b0100);
    wait_frame();
    for (int k = 1; k <= 16; k++) begin
      if (k == 6) begin
        bcd_in = 16'h5678;
        dp_in  = 4'b0000;
        load   = 1'b1;
      end
      check_step(k, segs_1234, 4'b0100);
      load = 1'b0;
    end
    check_frame(segs_5678, 4'b0000);

    // Two loads in one frame: last wins
    check_step(1, segs_5678, 4'b0000);
    do_load(16'h1111, 4'b1111);
    step();
    do_load(16'h2222, 4'b0000);
    wait_frame();
    check_frame(segs_2222, 4'b0000);

    // Load on the wrap cycle goes straight to the display
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        bcd_in = 16'h1234;
        dp_in  = 4'b0100;
        load   = 1'b1;
      end
      check_step(k, segs_2222, 4'b0000);
      load = 1'b0;
    end
    check_frame(segs_1234, 4'b0100);

    // Reset at index 2 with a pending value that must be discarded
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        bcd_in = 16'h9999;
        dp_in  = 4'b1111;
        load   = 1'b1;
      end
      check_step(k, segs_1234, 4'b0100);
      load = 1'b0;
    end
    reset = 1'b1;
    step();
    check_blank("mid_scan_reset");
    reset = 1'b0;
    check_frame(zero_segs, 4'b0000);
    check_frame(zero_segs, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
